upstream_risk_engine: RTL and testbench
=======================================

# upstream_risk_engine

Parametrised successor to the single-client upstream risk path. It holds per-client accumulated orders, downstream cancellations and max-to-trade limits in internal flop tables. It accepts orders over a valid/ready handshake, runs the pre-trade risk check, and commits accepted orders. It sits between the order-entry front end and the downstream sender, and adds a kill switch, saturating arithmetic and reject-reason reporting.

## Interface
- AMT_W, 32, width of amounts, limits and accumulators (unsigned)
- CID_W, 5, client-id width
- N_CLIENTS, 32, number of table entries; must be ≤ 2**CID_W
- clk  in  1  single clock, rising edge
- HRESETn  in  1  reset, asynchronous assert, active-low
- ord_valid  in  1  order request valid
- ord_ready  out  1  engine can accept an order
- ord_client_id  in  CID_W  order client
- ord_amount  in  AMT_W  order amount
- max_valid  in  1  limit write strobe, always accepted
- max_client_id  in  CID_W  limit target
- max_amount  in  AMT_W  new max_to_trade
- cxl_valid  in  1  downstream cancellation strobe, always accepted
- cxl_client_id  in  CID_W  cancellation target
- cxl_amount  in  AMT_W  cancelled amount to add
- kill  in  1  global kill switch, level-sensitive
- rsp_valid  out  1  one-cycle decision pulse
- rsp_client_id  out  CID_W  client of the decided order
- rsp_accept  out  1  1 = order passed and committed
- rsp_reason  out  2  0 ok, 1 over limit, 2 accumulator overflow, 3 blocked (kill or invalid id)
- rsp_exposure  out  AMT_W  acc − cxl for that client after commit, floored at 0

## Operation
- Per-client tables: acc[i], cxl[i], max[i], each AMT_W bits, for i < N_CLIENTS.
- FSM states:
  - IDLE: ord_ready=1. ord_valid&&ord_ready latches client id and amount, then goes to CHECK.
  - CHECK: ord_ready=0. The decision is computed from the current table values. On the next edge the engine commits, registers the response and returns to IDLE.
- Decision priority, in CHECK:
  - kill=1 or id ≥ N_CLIENTS → reason 3.
  - Else acc+amount > 2**AMT_W−1 → reason 2.
  - Else acc+amount > max+cxl → reason 1.
  - Else accept, reason 0.
- Arithmetic: all sums are computed in AMT_W+1 bits, unsigned, with no wrap.
- Commit: acc[id] ← acc+amount only when accepted. amount=0 can be accepted and leaves acc unchanged.
- Max write: max[id] ← max_amount on any cycle. An invalid id is ignored.
- Cancellation: cxl[id] ← cxl+cxl_amount on any cycle, saturating at all-ones. An invalid id is ignored.
- Simultaneous events in CHECK on the same client:
  - The decision uses the pre-edge max and cxl.
  - Max, cxl and acc updates all land on the same edge.
  - rsp_exposure reflects all updates landed on that edge.
- max_valid and cxl_valid arriving in the same cycle target independent tables, and both apply.

## Timing
- Reset (asynchronous, HRESETn=0):
  - All table entries go to 0. Limits are therefore 0, so only amount-0 orders pass.
  - State goes to IDLE, ord_ready=1, rsp_valid=0, and rsp_client_id/accept/reason/exposure go to 0.
  - A latched order is dropped with no response.
- Latency:
  - Order accepted at edge E0 → CHECK during E0..E1.
  - rsp_* are registered at E1, with rsp_valid high for exactly the cycle E1..E2.
  - ord_ready is 1 again after E1, so the next accept is at E2 at the earliest.
  - Throughput is 1 order per 2 cycles.
- The response has no backpressure.
- Back-to-back orders to the same client always see the committed acc; no forwarding is needed.
- kill is sampled only in CHECK. Toggling it in IDLE has no effect on accepted orders.
- ord_* inputs are ignored while ord_ready=0.

## Test plan
- Reset, then order id 3 amount 0 → accept, reason 0. Then order id 3 amount 1 → reject, reason 1, exposure 0.
- max[5]=100; orders 60 then 40 then 1 → accept (exp 60), accept (exp 100), reject reason 1 (exp 100).
- max[5]=100, acc=100; cxl 30 on id 5, then order 30 → accept, exposure 100. Same setup with cxl issued in the same cycle as CHECK → reject reason 1, cxl still counted afterwards.
- max[2]=2**AMT_W−1, acc[2]=2**AMT_W−10; order 20 → reject reason 2, acc unchanged.
- kill=1 during CHECK → reason 3. N_CLIENTS=20 with order id 25 → reason 3, and max write to id 25 is ignored.
- HRESETn pulsed low during CHECK → no rsp_valid, all tables 0, ord_ready=1 immediately.

Source files
------------

// File: rtl/upstream_risk_engine_if.sv
// Order, limit, cancellation and response bundle for the risk engine.
// The master drives requests; the engine (slave) drives ready and responses.
interface upstream_risk_engine_if #(
   parameter int AMT_W = 32,
   parameter int CID_W = 5
);
   logic             ord_valid;
   logic             ord_ready;
   logic [CID_W-1:0] ord_client_id;
   logic [AMT_W-1:0] ord_amount;
   logic             max_valid;
   logic [CID_W-1:0] max_client_id;
   logic [AMT_W-1:0] max_amount;
   logic             cxl_valid;
   logic [CID_W-1:0] cxl_client_id;
   logic [AMT_W-1:0] cxl_amount;
   logic             kill;
   logic             rsp_valid;
   logic [CID_W-1:0] rsp_client_id;
   logic             rsp_accept;
   logic [1:0]       rsp_reason;
   logic [AMT_W-1:0] rsp_exposure;

   modport master (
      output ord_valid, ord_client_id, ord_amount,
      output max_valid, max_client_id, max_amount,
      output cxl_valid, cxl_client_id, cxl_amount,
      output kill,
      input  ord_ready,
      input  rsp_valid, rsp_client_id, rsp_accept,
      input  rsp_reason, rsp_exposure
   );

   modport slave (
      input  ord_valid, ord_client_id, ord_amount,
      input  max_valid, max_client_id, max_amount,
      input  cxl_valid, cxl_client_id, cxl_amount,
      input  kill,
      output ord_ready,
      output rsp_valid, rsp_client_id, rsp_accept,
      output rsp_reason, rsp_exposure
   );
endinterface

// File: rtl/upstream_risk_engine.sv
// Multi-client pre-trade risk engine: per-client acc/cxl/max tables,
// two-cycle order check with kill switch, saturation and reject reasons.
module upstream_risk_engine #(
   parameter int AMT_W     = 32,
   parameter int CID_W     = 5,
   parameter int N_CLIENTS = 32
) (
   input logic                   clk,
   input logic                   HRESETn,
   upstream_risk_engine_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_CHECK
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_ord_ready;
   logic             w_take;

   logic [CID_W-1:0] r_id;
   logic [AMT_W-1:0] r_amt;

   logic [AMT_W-1:0] r_acc [N_CLIENTS];
   logic [AMT_W-1:0] r_cxl [N_CLIENTS];
   logic [AMT_W-1:0] r_max [N_CLIENTS];

   logic             w_id_ok;
   logic [AMT_W-1:0] w_acc;
   logic [AMT_W-1:0] w_cxl;
   logic [AMT_W-1:0] w_max;
   logic [AMT_W:0]   w_sum;
   logic [AMT_W:0]   w_lim;
   logic             w_accept;
   logic [1:0]       w_reason;
   logic             w_cxl_hit;
   logic [AMT_W-1:0] w_acc_new;
   logic [AMT_W-1:0] w_cxl_new;
   logic [AMT_W-1:0] w_expo;

   logic             r_rsp_valid;
   logic [CID_W-1:0] r_rsp_id;
   logic             r_rsp_accept;
   logic [1:0]       r_rsp_reason;
   logic [AMT_W-1:0] r_rsp_expo;

   function automatic logic [AMT_W-1:0] f_sat_add(
      input logic [AMT_W-1:0] a,
      input logic [AMT_W-1:0] b
   );
      logic [AMT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[AMT_W] ? '1 : s[AMT_W-1:0];
   endfunction

   // State register
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and order-side handshake
   always_comb begin
      w_state_nxt = r_state;
      w_ord_ready = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ord_ready = 1'b1;
            if (bus.ord_valid) w_state_nxt = S_CHECK;
         end
         S_CHECK: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_take = bus.ord_valid && w_ord_ready;

   // Latch the accepted order for the check cycle
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         r_id  <= '0;
         r_amt <= '0;
      end else if (w_take) begin
         r_id  <= bus.ord_client_id;
         r_amt <= bus.ord_amount;
      end
   end

   // Look up the latched client; out-of-range ids match no entry
   always_comb begin
      w_id_ok = 1'b0;
      w_acc   = '0;
      w_cxl   = '0;
      w_max   = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (r_id == CID_W'(i)) begin
            w_id_ok = 1'b1;
            w_acc   = r_acc[i];
            w_cxl   = r_cxl[i];
            w_max   = r_max[i];
         end
      end
   end

   // Risk decision on pre-edge table values, widened sums never wrap
   always_comb begin
      w_sum    = {1'b0, w_acc} + {1'b0, r_amt};
      w_lim    = {1'b0, w_max} + {1'b0, w_cxl};
      w_accept = 1'b0;
      w_reason = 2'd0;
      if (bus.kill || !w_id_ok)  w_reason = 2'd3;
      else if (w_sum[AMT_W])     w_reason = 2'd2;
      else if (w_sum > w_lim)    w_reason = 2'd1;
      else                       w_accept = 1'b1;
   end

   // Post-edge exposure, including a cancellation landing this edge
   always_comb begin
      w_cxl_hit = bus.cxl_valid && (bus.cxl_client_id == r_id);
      w_acc_new = w_accept ? w_sum[AMT_W-1:0] : w_acc;
      w_cxl_new = w_cxl_hit ? f_sat_add(w_cxl, bus.cxl_amount) : w_cxl;
      w_expo    = (w_acc_new > w_cxl_new) ? (w_acc_new - w_cxl_new) : '0;
   end

   // Table updates: limit writes, saturating cancels, order commits
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            r_acc[i] <= '0;
            r_cxl[i] <= '0;
            r_max[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CLIENTS; i++) begin
            if (bus.max_valid && bus.max_client_id == CID_W'(i))
               r_max[i] <= bus.max_amount;
            if (bus.cxl_valid && bus.cxl_client_id == CID_W'(i))
               r_cxl[i] <= f_sat_add(r_cxl[i], bus.cxl_amount);
            if (r_state == S_CHECK && w_accept && r_id == CID_W'(i))
               r_acc[i] <= w_sum[AMT_W-1:0];
         end
      end
   end

   // Registered one-cycle decision pulse
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_accept <= 1'b0;
         r_rsp_reason <= 2'd0;
         r_rsp_expo   <= '0;
      end else begin
         r_rsp_valid <= (r_state == S_CHECK);
         if (r_state == S_CHECK) begin
            r_rsp_id     <= r_id;
            r_rsp_accept <= w_accept;
            r_rsp_reason <= w_reason;
            r_rsp_expo   <= w_expo;
         end
      end
   end

   assign bus.ord_ready     = w_ord_ready;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_client_id = r_rsp_id;
   assign bus.rsp_accept    = r_rsp_accept;
   assign bus.rsp_reason    = r_rsp_reason;
   assign bus.rsp_exposure  = r_rsp_expo;

endmodule

// File: tb/tb_upstream_risk_engine.sv
// Directed bench for upstream_risk_engine (20 clients, 32-bit amounts).
// Expected results are hand-computed per scenario.
module tb_upstream_risk_engine;
   localparam int AW = 32;
   localparam int CW = 5;

   logic clk;
   logic HRESETn;
   int   checks;
   int   failures;

   upstream_risk_engine_if #(.AMT_W(AW), .CID_W(CW)) bus ();

   upstream_risk_engine #(
      .AMT_W(AW), .CID_W(CW), .N_CLIENTS(20)
   ) dut (
      .clk(clk),
      .HRESETn(HRESETn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr(input bit mv, input logic [4:0] mid, input logic [31:0] ma,
                     input bit cv, input logic [4:0] cid, input logic [31:0] ca);
      @(negedge clk);
      bus.max_valid = mv; bus.max_client_id = mid; bus.max_amount = ma;
      bus.cxl_valid = cv; bus.cxl_client_id = cid; bus.cxl_amount = ca;
      @(posedge clk); #1;
      bus.max_valid = 1'b0; bus.cxl_valid = 1'b0;
   endtask

   task automatic order(input logic [4:0] id, input logic [31:0] amt,
                        output logic [34:0] res,
                        input bit k = 0,
                        input bit cv = 0, input logic [4:0] cid = 0,
                        input logic [31:0] camt = 0,
                        input bit mv = 0, input logic [4:0] mid = 0,
                        input logic [31:0] mamt = 0);
      @(negedge clk);
      checks++;
      if (bus.ord_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_state ready=%b rsp_valid=%b exp 1/0",
                  bus.ord_ready, bus.rsp_valid);
      end
      bus.ord_valid = 1'b1; bus.ord_client_id = id; bus.ord_amount = amt;
      @(posedge clk); #1;
      bus.ord_valid = 1'b0;
      bus.kill = k;
      bus.cxl_valid = cv; bus.cxl_client_id = cid; bus.cxl_amount = camt;
      bus.max_valid = mv; bus.max_client_id = mid; bus.max_amount = mamt;
      @(negedge clk);
      checks++;
      if (bus.ord_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL check_state ready=%b rsp_valid=%b exp 0/0",
                  bus.ord_ready, bus.rsp_valid);
      end
      @(posedge clk); #1;
      bus.kill = 1'b0; bus.cxl_valid = 1'b0; bus.max_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_client_id !== id) begin
         failures++;
         $display("FAIL rsp_timing valid=%b id=%0d exp 1/%0d",
                  bus.rsp_valid, bus.rsp_client_id, id);
      end
      res = {bus.rsp_accept, bus.rsp_reason, bus.rsp_exposure};
   endtask

   task automatic test_reset;
      logic [34:0] r;
      checks++;
      if (bus.ord_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
          {bus.rsp_client_id, bus.rsp_accept, bus.rsp_reason, bus.rsp_exposure} !== '0) begin
         failures++;
         $display("FAIL reset_outputs ready=%b valid=%b id=%0d acc=%b rsn=%0d exp=%0d",
                  bus.ord_ready, bus.rsp_valid, bus.rsp_client_id,
                  bus.rsp_accept, bus.rsp_reason, bus.rsp_exposure);
      end
      order(3, 0, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd0}) begin
         failures++; $display("FAIL zero_amount got=%h exp=%h", r, {1'b1, 2'd0, 32'd0});
      end
      order(3, 1, r);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd0}) begin
         failures++; $display("FAIL zero_limit got=%h exp=%h", r, {1'b0, 2'd1, 32'd0});
      end
   endtask

   task automatic test_limit;
      logic [34:0] r;
      wr(1, 5, 100, 0, 0, 0);
      order(5, 60, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd60}) begin
         failures++; $display("FAIL limit_60 got=%h exp=%h", r, {1'b1, 2'd0, 32'd60});
      end
      order(5, 40, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd100}) begin
         failures++; $display("FAIL limit_100 got=%h exp=%h", r, {1'b1, 2'd0, 32'd100});
      end
      order(5, 1, r);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd100}) begin
         failures++; $display("FAIL limit_over got=%h exp=%h", r, {1'b0, 2'd1, 32'd100});
      end
   endtask

   task automatic test_cancel;
      logic [34:0] r;
      wr(0, 0, 0, 1, 5, 30);
      order(5, 30, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd100}) begin
         failures++; $display("FAIL cxl_credit got=%h exp=%h", r, {1'b1, 2'd0, 32'd100});
      end
      wr(1, 6, 100, 0, 0, 0);
      order(6, 100, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd100}) begin
         failures++; $display("FAIL cxl_setup got=%h exp=%h", r, {1'b1, 2'd0, 32'd100});
      end
      order(6, 30, r, 0, 1, 6, 30);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd70}) begin
         failures++; $display("FAIL cxl_in_check got=%h exp=%h", r, {1'b0, 2'd1, 32'd70});
      end
      order(6, 30, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd100}) begin
         failures++; $display("FAIL cxl_after got=%h exp=%h", r, {1'b1, 2'd0, 32'd100});
      end
   endtask

   task automatic test_max_in_check;
      logic [34:0] r;
      order(9, 5, r, 0, 0, 0, 0, 1, 9, 100);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd0}) begin
         failures++; $display("FAIL max_in_check got=%h exp=%h", r, {1'b0, 2'd1, 32'd0});
      end
      order(9, 5, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd5}) begin
         failures++; $display("FAIL max_landed got=%h exp=%h", r, {1'b1, 2'd0, 32'd5});
      end
   endtask

   task automatic test_max_cxl_same_cycle;
      logic [34:0] r;
      wr(1, 8, 50, 1, 8, 10);
      order(8, 60, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd50}) begin
         failures++; $display("FAIL both_apply got=%h exp=%h", r, {1'b1, 2'd0, 32'd50});
      end
      order(8, 1, r);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd50}) begin
         failures++; $display("FAIL both_limit got=%h exp=%h", r, {1'b0, 2'd1, 32'd50});
      end
   endtask

   task automatic test_overflow;
      logic [34:0] r;
      wr(1, 2, 32'hFFFF_FFFF, 0, 0, 0);
      order(2, 32'hFFFF_FFF6, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'hFFFF_FFF6}) begin
         failures++; $display("FAIL ovf_setup got=%h exp=%h", r, {1'b1, 2'd0, 32'hFFFF_FFF6});
      end
      order(2, 20, r);
      checks++;
      if (r !== {1'b0, 2'd2, 32'hFFFF_FFF6}) begin
         failures++; $display("FAIL ovf_reject got=%h exp=%h", r, {1'b0, 2'd2, 32'hFFFF_FFF6});
      end
      order(2, 9, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'hFFFF_FFFF}) begin
         failures++; $display("FAIL ovf_edge got=%h exp=%h", r, {1'b1, 2'd0, 32'hFFFF_FFFF});
      end
   endtask

   task automatic test_cxl_saturate;
      logic [34:0] r;
      wr(0, 0, 0, 1, 7, 32'hFFFF_FFF0);
      wr(0, 0, 0, 1, 7, 32'h20);
      order(7, 32'h20, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd0}) begin
         failures++; $display("FAIL cxl_sat got=%h exp=%h", r, {1'b1, 2'd0, 32'd0});
      end
   endtask

   task automatic test_kill;
      logic [34:0] r;
      order(5, 0, r, 1);
      checks++;
      if (r !== {1'b0, 2'd3, 32'd100}) begin
         failures++; $display("FAIL kill_check got=%h exp=%h", r, {1'b0, 2'd3, 32'd100});
      end
      @(negedge clk); bus.kill = 1'b1;
      @(negedge clk); bus.kill = 1'b0;
      order(5, 0, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd100}) begin
         failures++; $display("FAIL kill_idle got=%h exp=%h", r, {1'b1, 2'd0, 32'd100});
      end
   endtask

   task automatic test_bad_id;
      logic [34:0] r;
      wr(1, 25, 1000, 1, 25, 5);
      order(25, 0, r);
      checks++;
      if (r !== {1'b0, 2'd3, 32'd0}) begin
         failures++; $display("FAIL id25 got=%h exp=%h", r, {1'b0, 2'd3, 32'd0});
      end
      order(20, 0, r);
      checks++;
      if (r !== {1'b0, 2'd3, 32'd0}) begin
         failures++; $display("FAIL id20 got=%h exp=%h", r, {1'b0, 2'd3, 32'd0});
      end
      order(19, 0, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd0}) begin
         failures++; $display("FAIL id19 got=%h exp=%h", r, {1'b1, 2'd0, 32'd0});
      end
      order(5, 1, r);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd100}) begin
         failures++; $display("FAIL id5_intact got=%h exp=%h", r, {1'b0, 2'd1, 32'd100});
      end
   endtask

   task automatic test_back_to_back;
      logic [34:0] r;
      wr(1, 11, 100, 0, 0, 0);
      @(negedge clk);
      bus.ord_valid = 1'b1; bus.ord_client_id = 11; bus.ord_amount = 10;
      @(negedge clk);
      bus.ord_amount = 20;
      @(negedge clk);
      r = {bus.rsp_accept, bus.rsp_reason, bus.rsp_exposure};
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.ord_ready !== 1'b1 ||
          r !== {1'b1, 2'd0, 32'd10}) begin
         failures++;
         $display("FAIL b2b_first valid=%b ready=%b got=%h exp=%h",
                  bus.rsp_valid, bus.ord_ready, r, {1'b1, 2'd0, 32'd10});
      end
      @(negedge clk);
      bus.ord_amount = 99;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.ord_ready !== 1'b0) begin
         failures++;
         $display("FAIL b2b_gap valid=%b ready=%b exp 0/0", bus.rsp_valid, bus.ord_ready);
      end
      @(negedge clk);
      bus.ord_valid = 1'b0;
      r = {bus.rsp_accept, bus.rsp_reason, bus.rsp_exposure};
      checks++;
      if (bus.rsp_valid !== 1'b1 || r !== {1'b1, 2'd0, 32'd30}) begin
         failures++;
         $display("FAIL b2b_second valid=%b got=%h exp=%h",
                  bus.rsp_valid, r, {1'b1, 2'd0, 32'd30});
      end
   endtask

   task automatic test_reset_in_check;
      logic [34:0] r;
      wr(1, 10, 50, 0, 0, 0);
      @(negedge clk);
      bus.ord_valid = 1'b1; bus.ord_client_id = 10; bus.ord_amount = 5;
      @(posedge clk); #1;
      bus.ord_valid = 1'b0;
      #2 HRESETn = 1'b0;
      #1;
      checks++;
      if (bus.ord_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_async ready=%b valid=%b exp 1/0", bus.ord_ready, bus.rsp_valid);
      end
      @(posedge clk);
      @(negedge clk);
      HRESETn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rst_no_rsp valid=%b exp 0", bus.rsp_valid);
         end
      end
      order(10, 5, r);
      checks++;
      if (r !== {1'b0, 2'd1, 32'd0}) begin
         failures++; $display("FAIL rst_max got=%h exp=%h", r, {1'b0, 2'd1, 32'd0});
      end
      order(5, 0, r);
      checks++;
      if (r !== {1'b1, 2'd0, 32'd0}) begin
         failures++; $display("FAIL rst_acc got=%h exp=%h", r, {1'b1, 2'd0, 32'd0});
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      HRESETn = 1'b0;
      bus.ord_valid = 1'b0; bus.ord_client_id = '0; bus.ord_amount = '0;
      bus.max_valid = 1'b0; bus.max_client_id = '0; bus.max_amount = '0;
      bus.cxl_valid = 1'b0; bus.cxl_client_id = '0; bus.cxl_amount = '0;
      bus.kill = 1'b0;
      repeat (2) @(negedge clk);
      HRESETn = 1'b1;
      test_reset();
      test_limit();
      test_cancel();
      test_max_in_check();
      test_max_cxl_same_cycle();
      test_overflow();
      test_cxl_saturate();
      test_kill();
      test_bad_id();
      test_back_to_back();
      test_reset_in_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
